mm_bist_sequencer: RTL and testbench

Self-test controller for the group3 matrix-mult test wrapper. It steps through a fixed table of test configurations, one per test. For each test it:
- drives the wrapper's test-config fields (bypass, mode, driver valid, stop code) plus `start`/`ext_en`,
- waits for the signature analyzer's valid output,
- compares the signature with a per-test golden value.

It sits beside the wrapper, replacing manual test-config driving on the tester, and reports per-test pass/fail.

---
 rtl/mm_bist_pkg.sv | 42 ++++
 rtl/mm_bist_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_mm_bist_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_bist_pkg.sv
// Shared types and the built-in test table for the matrix-mult self-test sequencer.
package mm_bist_pkg;

  typedef struct packed {
    logic [2:0] bypass;
    logic [1:0] mode;
    logic       ext_en;
  } test_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_GAP    = 3'd5,
    ST_FINISH = 3'd6
  } bist_state_e;

  localparam logic [2:0] BYP_NONE   = 3'b000;
  localparam logic [2:0] BYP_DRIVER = 3'b001;
  localparam logic [2:0] BYP_DUT    = 3'b010;
  localparam logic [2:0] BYP_SA     = 3'b100;

  localparam logic [1:0] MODE_EXT  = 2'b00;
  localparam logic [1:0] MODE_LFSR = 2'b01;

  localparam int TABLE_DEPTH = 4;

  localparam test_entry_t TEST_TABLE [TABLE_DEPTH] = '{
    '{bypass: BYP_DRIVER | BYP_DUT | BYP_SA, mode: MODE_EXT,  ext_en: 1'b1},
    '{bypass: BYP_NONE,                      mode: MODE_LFSR, ext_en: 1'b1},
    '{bypass: BYP_DRIVER,                    mode: MODE_EXT,  ext_en: 1'b1},
    '{bypass: BYP_DUT | BYP_SA,              mode: MODE_LFSR, ext_en: 1'b1}
  };

  // Campaigns longer than the table reuse its entries cyclically.
  function automatic test_entry_t get_test_entry(input logic [1:0] sel);
    return TEST_TABLE[sel];
  endfunction

endpackage

// File: rtl/mm_bist_sequencer.sv
// Self-test sequencer: walks the test table, launches the matrix-mult wrapper for each
// entry, and compares the returned signature with a per-test golden value.
module mm_bist_sequencer
  import mm_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_TESTS  = 4,
  parameter int SETTLE     = 2,
  parameter int TIMEOUT    = 1024,
  parameter int GAP        = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            run_i,
  input  logic                            abort_i,
  input  logic [DATA_WIDTH-1:0]           stop_code_i,
  input  logic [NUM_TESTS*DATA_WIDTH-1:0] golden_i,
  input  logic                            sig_valid_i,
  input  logic [DATA_WIDTH-1:0]           sig_data_i,
  output logic [2:0]                      bypass_o,
  output logic [1:0]                      mode_o,
  output logic                            driver_valid_o,
  output logic [DATA_WIDTH-1:0]           stop_code_o,
  output logic                            ext_en_o,
  output logic                            mm_start_o,
  output logic                            busy_o,
  output logic [((NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1)-1:0] cur_test_o,
  output logic [NUM_TESTS-1:0]            fail_mask_o,
  output logic                            done_o,
  output logic                            pass_o
);

  localparam int IDX_W   = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? ((TIMEOUT > GAP) ? TIMEOUT : GAP)
                                              : ((SETTLE > GAP) ? SETTLE : GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TESTS - 1);

  bist_state_e             state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [NUM_TESTS-1:0]    mask_r, mask_s;
  logic                    done_r, done_s;
  logic [DATA_WIDTH-1:0]   sig_r, sig_s;
  logic                    run_r, run_d_r, run_rise_s;
  logic [DATA_WIDTH-1:0]   golden_slice_s;

  test_entry_t             entry_s;
  logic [2:0]              bypass_r, bypass_s;
  logic [1:0]              mode_r, mode_s;
  logic                    ext_en_r, ext_en_s;
  logic                    start_r, start_s;
  logic                    busy_r, busy_s;
  logic                    pass_r, pass_s;

  assign run_rise_s     = run_r & ~run_d_r;
  assign golden_slice_s = golden_i[int'(idx_r) * DATA_WIDTH +: DATA_WIDTH];

  // Next-state, shared down-counter and campaign bookkeeping.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    mask_s  = mask_r;
    done_s  = done_r;
    sig_s   = sig_r;
    case (state_r)
      ST_IDLE: begin
        if (run_rise_s) begin
          state_s = ST_CONFIG;
          cnt_s   = SETTLE_LD;
          idx_s   = {IDX_W{1'b0}};
          mask_s  = {NUM_TESTS{1'b0}};
          done_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CONFIG: begin
        if (cnt_r == CNT_W'(0)) begin
          state_s = ST_LAUNCH;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_LAUNCH: begin
        cnt_s   = TIMEOUT_LD;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A signature arriving on the timeout cycle still counts as completed.
        if (sig_valid_i) begin
          sig_s   = sig_data_i;
          state_s = ST_CHECK;
        end else if (cnt_r == CNT_W'(0)) begin
          mask_s[idx_r] = 1'b1;
          cnt_s         = GAP_LD;
          state_s       = ST_GAP;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (sig_r != golden_slice_s) begin
          mask_s[idx_r] = 1'b1;
        end else begin
          mask_s = mask_r;
        end
        cnt_s   = GAP_LD;
        state_s = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_r != CNT_W'(0)) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else if (idx_r == LAST_IDX) begin
          done_s  = 1'b1;
          state_s = ST_FINISH;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          cnt_s   = SETTLE_LD;
          state_s = ST_CONFIG;
        end
      end
      ST_FINISH: begin
        if (!run_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FINISH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Abort drops the campaign with results frozen as they were.
    if (abort_i && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      mask_s  = mask_r;
      done_s  = done_r;
      sig_s   = sig_r;
    end else begin
      sig_s = sig_s;
    end
  end

  // Output values for the upcoming state, registered below.
  always_comb begin
    entry_s  = get_test_entry(2'(idx_s));
    bypass_s = 3'b000;
    mode_s   = 2'b00;
    ext_en_s = 1'b0;
    start_s  = 1'b0;
    busy_s   = 1'b0;
    case (state_s)
      ST_CONFIG, ST_CHECK, ST_GAP: begin
        busy_s   = 1'b1;
        bypass_s = entry_s.bypass;
        mode_s   = entry_s.mode;
        ext_en_s = entry_s.ext_en;
      end
      ST_LAUNCH, ST_WAIT: begin
        busy_s   = 1'b1;
        start_s  = 1'b1;
        bypass_s = entry_s.bypass;
        mode_s   = entry_s.mode;
        ext_en_s = entry_s.ext_en;
      end
      ST_IDLE, ST_FINISH: begin
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
    pass_s = done_s & ~(|mask_s);
  end

  // State, counter, results and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_W'(0);
      idx_r    <= {IDX_W{1'b0}};
      mask_r   <= {NUM_TESTS{1'b0}};
      done_r   <= 1'b0;
      sig_r    <= {DATA_WIDTH{1'b0}};
      bypass_r <= 3'b000;
      mode_r   <= 2'b00;
      ext_en_r <= 1'b0;
      start_r  <= 1'b0;
      busy_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      mask_r   <= mask_s;
      done_r   <= done_s;
      sig_r    <= sig_s;
      bypass_r <= bypass_s;
      mode_r   <= mode_s;
      ext_en_r <= ext_en_s;
      start_r  <= start_s;
      busy_r   <= busy_s;
      pass_r   <= pass_s;
    end
  end

  // run_i edge detector; resets high so a run_i held across reset is not a new edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_r   <= 1'b1;
      run_d_r <= 1'b1;
    end else begin
      run_r   <= run_i;
      run_d_r <= run_r;
    end
  end

  assign stop_code_o    = stop_code_i;
  assign bypass_o       = bypass_r;
  assign mode_o         = mode_r;
  assign ext_en_o       = ext_en_r;
  assign mm_start_o     = start_r;
  assign driver_valid_o = start_r;
  assign busy_o         = busy_r;
  assign cur_test_o     = idx_r;
  assign fail_mask_o    = mask_r;
  assign done_o         = done_r;
  assign pass_o         = pass_r;

endmodule

// File: tb/tb_mm_bist_sequencer.sv
// Scoreboard bench for mm_bist_sequencer: a wrapper model answers each launch, and a
// monitor checks every start pulse and every campaign result against queued expectations.
module tb_mm_bist_sequencer;

  localparam int DW      = 64;
  localparam int NT      = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  typedef struct { int test; int len; int gap; } pulse_t;
  typedef struct { logic [NT-1:0] mask; logic pass; } camp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, run, abort;
  logic [DW-1:0]    stop_code;
  logic [NT*DW-1:0] golden;
  logic             sig_valid;
  logic [DW-1:0]    sig_data;
  logic [2:0]       bypass;
  logic [1:0]       mode;
  logic             driver_valid, ext_en, mm_start, busy, done, pass;
  logic [DW-1:0]    stop_code_out;
  logic [1:0]       cur_test;
  logic [NT-1:0]    fail_mask;

  pulse_t pulse_q[$];
  camp_t  camp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     resp_d [NT];

  logic [DW-1:0] sig_tab  [NT] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'h5A5A_A5A5_0F0F_F0F0, 64'h1111_2222_3333_4444};
  logic [2:0]    exp_byp  [NT] = '{3'b111, 3'b000, 3'b001, 3'b110};
  logic [1:0]    exp_mode [NT] = '{2'b00, 2'b01, 2'b00, 2'b01};

  mm_bist_sequencer #(
    .DATA_WIDTH(DW), .NUM_TESTS(NT), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .GAP(GAP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .abort_i(abort),
    .stop_code_i(stop_code), .golden_i(golden),
    .sig_valid_i(sig_valid), .sig_data_i(sig_data),
    .bypass_o(bypass), .mode_o(mode), .driver_valid_o(driver_valid),
    .stop_code_o(stop_code_out), .ext_en_o(ext_en), .mm_start_o(mm_start),
    .busy_o(busy), .cur_test_o(cur_test), .fail_mask_o(fail_mask),
    .done_o(done), .pass_o(pass)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_golden(input logic [NT-1:0] flip);
    for (int k = 0; k < NT; k++) begin
      golden[k*DW +: DW] = sig_tab[k] ^ {{(DW-1){1'b0}}, flip[k]};
    end
  endtask

  task automatic push_pulse(input int test, input int len, input int gap);
    pulse_t p;
    p.test = test; p.len = len; p.gap = gap;
    pulse_q.push_back(p);
  endtask

  // Start-high length is LAUNCH plus WAIT cycles; low gap is CHECK (if any) + GAP + SETTLE.
  task automatic push_campaign(input logic [NT-1:0] mask);
    camp_t c;
    for (int k = 0; k < NT; k++) begin
      push_pulse(k, (resp_d[k] > 0) ? resp_d[k] + 1 : TIMEOUT + 1,
                 (k == 0) ? -1 : ((resp_d[k-1] > 0) ? 1 + GAP + SETTLE : GAP + SETTLE));
    end
    c.mask = mask; c.pass = (mask == {NT{1'b0}});
    camp_q.push_back(c);
  endtask

  task automatic run_campaign(input logic [NT-1:0] flip, input logic [NT-1:0] exp_mask,
                              input string tag);
    int cyc;
    set_golden(flip);
    push_campaign(exp_mask);
    run = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_lat1"}, busy, 1'b0);
    @(negedge clk);
    chk({tag, "_busy_lat2"}, busy, 1'b1);
    chk({tag, "_start_idx"}, cur_test, 2'd0);
    chk({tag, "_mask_clr"}, fail_mask, 4'b0000);
    chk({tag, "_done_clr"}, done, 1'b0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    repeat (2) @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, done, 1'b1);
    chk({tag, "_mask_held"}, fail_mask, exp_mask);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  // Wrapper model: answers in WAIT cycle resp_d[test] (0 = never).
  initial begin
    int n;
    n = 0;
    sig_valid = 1'b0;
    sig_data  = {DW{1'b0}};
    forever begin
      @(negedge clk);
      if (mm_start && !rst) begin
        n++;
        sig_valid = (resp_d[cur_test] > 0) && (n == resp_d[cur_test] + 1);
        sig_data  = sig_tab[cur_test];
      end else begin
        n = 0;
        sig_valid = 1'b0;
      end
    end
  end

  // Monitor: checks each completed start pulse and each campaign report.
  initial begin
    bit         prev_start, prev_done;
    int         high_len, low_len, gap_seen, r_test;
    logic [2:0] r_byp;
    logic [1:0] r_mode;
    logic       r_ext, r_dv;
    pulse_t     p;
    camp_t      c;
    prev_start = 0; prev_done = 0; high_len = 0; low_len = 0; gap_seen = 0; r_test = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 0; prev_done = 0; high_len = 0; low_len = 0;
      end else begin
        if (mm_start) begin
          if (!prev_start) begin
            r_test = int'(cur_test); r_byp = bypass; r_mode = mode;
            r_ext = ext_en; r_dv = driver_valid; gap_seen = low_len;
          end
          high_len++;
        end else begin
          if (prev_start) begin
            if (pulse_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL pulse_unexpected: got start pulse for test %0d, expected none", r_test);
            end else begin
              p = pulse_q.pop_front();
              chk("pulse_test", r_test, p.test);
              chk("pulse_bypass", r_byp, exp_byp[p.test]);
              chk("pulse_mode", r_mode, exp_mode[p.test]);
              chk("pulse_ext_en", r_ext, 1'b1);
              chk("pulse_drv_valid", r_dv, 1'b1);
              chk("pulse_len", high_len, p.len);
              if (p.gap >= 0) chk("pulse_gap", gap_seen, p.gap);
            end
            high_len = 0;
            low_len  = 0;
          end
          low_len++;
        end
        if (done && !prev_done) begin
          if (camp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_unexpected: got done with mask %0h, expected none", fail_mask);
          end else begin
            c = camp_q.pop_front();
            chk("camp_mask", fail_mask, c.mask);
            chk("camp_pass", pass, c.pass);
            chk("camp_busy", busy, 1'b0);
          end
        end
        prev_start = mm_start;
        prev_done  = done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int  cyc, hits;
    bit  seen;
    rst = 1'b1; run = 1'b0; abort = 1'b0;
    stop_code = 64'hA5A5_0000_DEAD_BEEF;
    resp_d = '{1, 1, 1, 1};
    set_golden(4'b0000);
    repeat (3) @(negedge clk);
    chk("rst_bypass", bypass, 3'b000);
    chk("rst_mode", mode, 2'b00);
    chk("rst_ext_en", ext_en, 1'b0);
    chk("rst_start", mm_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_mask", fail_mask, 4'b0000);
    chk("stop_code_pass", stop_code_out, 64'hA5A5_0000_DEAD_BEEF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    resp_d = '{1, 2, 1, 3};
    run_campaign(4'b0000, 4'b0000, "all_pass");
    resp_d = '{1, 1, 1, 1};
    run_campaign(4'b0100, 4'b0100, "golden2_bad");
    resp_d = '{1, 0, 2, 1};
    run_campaign(4'b0000, 4'b0010, "timeout1");
    resp_d = '{16, 1, 1, 15};
    run_campaign(4'b0000, 4'b0000, "valid_at_timeout");

    stop_code = 64'h0F0F_1234_5678_9ABC;
    #1;
    chk("stop_code_follow", stop_code_out, 64'h0F0F_1234_5678_9ABC);

    // Abort in WAIT of test 1 after test 0 failed its compare.
    resp_d = '{1, 0, 1, 1};
    set_golden(4'b0001);
    push_pulse(0, 2, -1);
    push_pulse(1, 4, 1 + GAP + SETTLE);
    run = 1'b1;
    cyc = 0;
    while (!(mm_start && cur_test == 2'd1) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach_test1", mm_start && cur_test == 2'd1, 1'b1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_start", mm_start, 1'b0);
    chk("abort_drv_valid", driver_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_mask_held", fail_mask, 4'b0001);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", busy, 1'b0);
    run = 1'b0;
    repeat (3) @(negedge clk);
    resp_d = '{1, 1, 1, 1};
    run_campaign(4'b0000, 4'b0000, "after_abort");

    // Reset during CHECK of test 2 with test 1 already failed.
    resp_d = '{1, 1, 1, 1};
    set_golden(4'b0010);
    push_pulse(0, 2, -1);
    push_pulse(1, 2, 1 + GAP + SETTLE);
    push_pulse(2, 2, 1 + GAP + SETTLE);
    run = 1'b1;
    seen = 0;
    cyc  = 0;
    while (cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (mm_start && cur_test == 2'd2) seen = 1;
      else if (seen && !mm_start) break;
    end
    chk("rst_reach_check", seen && !mm_start, 1'b1);
    chk("pre_rst_mask", fail_mask, 4'b0010);
    chk("pre_rst_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_bypass", bypass, 3'b000);
    chk("arst_ext_en", ext_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cur_test", cur_test, 2'd0);
    chk("arst_mask", fail_mask, 4'b0000);
    chk("arst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (mm_start || busy) hits++;
    end
    chk("no_retrigger", hits, 0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    resp_d = '{2, 1, 1, 1};
    run_campaign(4'b0000, 4'b0000, "after_reset");

    chk("pulse_queue_empty", pulse_q.size(), 0);
    chk("camp_queue_empty", camp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
